// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  typedef logic [3:0] key_code_t;

  // Index of the lowest row pulled low; row 0 wins when several are low.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones to match idle pulled-up rows.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with debounce and digit entry register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_CNT_WIDTH = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            row_n,
  input  logic                  clr,
  output logic [3:0]            col_n,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic [DIGITS*4-1:0]   val
);

  localparam int unsigned VAL_W = DIGITS * 4;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned CNT_MAX = (REPEAT_SCANS > DEBOUNCE_SCANS) ? REPEAT_SCANS : DEBOUNCE_SCANS;
`else
  localparam int unsigned CNT_MAX = DEBOUNCE_SCANS;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_SCANS);
`endif

  if (DIGITS < 1 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("hex_keypad_scanner: DIGITS, DEBOUNCE_SCANS and REPEAT_SCANS must be >= 1");
  end

  logic [ROWS-1:0] row_sync;

  sync_2ff #(.WIDTH(ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (row_sync)
  );

  state_e                    state_q, state_d;
  logic [1:0]                col_idx_q, col_idx_d;
  logic [1:0]                row_q, row_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SCAN_CNT_WIDTH-1:0] scan_cnt_q, scan_cnt_d;
  logic [COLS-1:0]           col_n_q, col_n_d;
  logic                      key_valid_q, key_valid_d;
  key_code_t                 key_code_q, key_code_d;
  logic [VAL_W-1:0]          val_q, val_d;

  logic             tick;
  logic             any_low;
  logic             latched_low;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  key_code_t        code;

  assign tick        = &scan_cnt_q;
  assign any_low     = (row_sync != '1);
  assign latched_low = !row_sync[row_q];
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign code        = {row_q, col_idx_q};

  // Scan/debounce state machine; every decision is taken on a scan tick.
  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    scan_cnt_d = scan_cnt_q + SCAN_CNT_WIDTH'(1);
    accept     = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            row_d   = lowest_low_row(row_sync);
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (latched_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_LIM) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!latched_low) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(1);
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= REP_LIM) begin
              accept = 1'b1;
              cnt_d  = '0;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (latched_low) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_LIM) begin
              state_d   = ST_SCAN;
              cnt_d     = '0;
              col_idx_d = col_idx_q + 2'd1;
            end
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // Output register inputs; clr beats a same-cycle accept for val only.
  always_comb begin
    col_n_d     = ~(COLS'(1) << col_idx_q);
    key_valid_d = accept;
    key_code_d  = accept ? code : key_code_q;
    val_d       = val_q;
    if (clr) begin
      val_d = '0;
    end else if (accept) begin
      val_d = (val_q << 4) | VAL_W'(code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      scan_cnt_q  <= '0;
      col_n_q     <= '1;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      val_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      col_n_q     <= col_n_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      val_q       <= val_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign val       = val_q;

endmodule
